// File: rtl/sram_pkg.sv
// Shared types and defaults for the serial-load SRAM burst controller.
package sram_pkg;

  localparam int DEF_ROWS = 16;
  localparam int DEF_COLS = 8;
  localparam int ADDR_W   = $clog2(DEF_ROWS);

  typedef enum logic [1:0] {
    OP_WR  = 2'b00,
    OP_RD  = 2'b01,
    OP_BWR = 2'b10,
    OP_BRD = 2'b11
  } sram_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP,
    ST_WRITE,
    ST_READ,
    ST_WAIT_RD
  } ctrl_state_e;

  function automatic logic op_is_write(sram_op_e op);
    return (op == OP_WR) || (op == OP_BWR);
  endfunction

  function automatic logic op_is_burst(sram_op_e op);
    return (op == OP_BWR) || (op == OP_BRD);
  endfunction

endpackage

// File: rtl/sram_serializer.sv
// Parallel-in serial-out shifter: LANES slices sent MSB first, each bit held SHIFT_DIV clocks.
module sram_serializer #(
  parameter int COLS      = 8,
  parameter int LANES     = 1,
  parameter int SHIFT_DIV = 2
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             load,
  input  logic [COLS-1:0]  word,
  output logic [LANES-1:0] serial_in,
  output logic             shift,
  output logic             done
);

  localparam int W  = COLS / LANES;
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam int DW = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;

  logic [COLS-1:0] word_q;
  logic            active;
  logic [BW-1:0]   bit_cnt;
  logic [DW-1:0]   div_cnt;
  logic            last_div;
  logic            last_bit;

  assign last_div = (div_cnt == DW'(SHIFT_DIV - 1));
  assign last_bit = (bit_cnt == BW'(W - 1));
  assign shift    = active;
  assign done     = active && last_div && last_bit;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      word_q  <= '0;
      active  <= 1'b0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (load) begin
      word_q  <= word;
      active  <= 1'b1;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (active) begin
      if (last_div) begin
        div_cnt <= '0;
        if (last_bit) active <= 1'b0;
        else          bit_cnt <= bit_cnt + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // The word is indexed rather than shifted, so each lane picks its slice MSB-down.
  always_comb begin
    serial_in = '0;
    for (int l = 0; l < LANES; l++) begin
      if (active) serial_in[l] = word_q[l*W + (W - 1) - int'(bit_cnt)];
    end
  end

endmodule

// File: rtl/sram_burst_ctrl.sv
// Command-driven master for the serial-load SRAM: single/burst writes via the serializer, reads with timeout.
module sram_burst_ctrl
  import sram_pkg::*;
#(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int LANES      = 1,
  parameter int SHIFT_DIV  = 2,
  parameter int RD_TIMEOUT = 8
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [$clog2(ROWS)-1:0] cmd_addr,
  input  logic [$clog2(ROWS)-1:0] cmd_len,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [COLS-1:0]         wr_data,
  output logic [LANES-1:0]        serial_in,
  output logic                    shift,
  output logic                    w_en,
  output logic                    r_en,
  output logic [$clog2(ROWS)-1:0] addr,
  input  logic                    sram_data_valid,
  input  logic [COLS-1:0]         sram_data_out,
  output logic                    rd_valid,
  output logic [COLS-1:0]         rd_data,
  output logic [$clog2(ROWS)-1:0] rd_addr,
  output logic                    busy,
  output logic                    err_timeout,
  output logic [2:0]              dbg_state
);

  localparam int AW = $clog2(ROWS);
  localparam int RW = AW + 1;
  localparam int TW = $clog2(RD_TIMEOUT + 1);

  ctrl_state_e   state, state_nx;
  sram_op_e      op;
  logic [AW-1:0] addr_q;
  logic [RW-1:0] rem_q;
  logic [RW-1:0] cmd_rows;
  logic [TW-1:0] to_cnt;
  logic          ser_done;
  logic          last_row;
  logic          to_expire;
  logic          row_done;

  assign op        = sram_op_e'(cmd_op);
  assign cmd_rows  = !op_is_burst(op) ? RW'(1) :
                     (cmd_len == '0)  ? RW'(ROWS) : {1'b0, cmd_len};
  assign last_row  = (rem_q == RW'(1));
  assign to_expire = (to_cnt == TW'(RD_TIMEOUT - 1));
  assign row_done  = (state == ST_WRITE) || (state == ST_WAIT_RD && sram_data_valid);
  assign busy      = (state != ST_IDLE);
  assign addr      = addr_q;
  assign dbg_state = state;

  sram_serializer #(
    .COLS      (COLS),
    .LANES     (LANES),
    .SHIFT_DIV (SHIFT_DIV)
  ) u_ser (
    .clk       (clk),
    .arst_n    (arst_n),
    .load      (state == ST_LOAD && wr_valid),
    .word      (wr_data),
    .serial_in (serial_in),
    .shift     (shift),
    .done      (ser_done)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // Both ports transfer on a cycle where valid and ready are high together;
  // ready depends only on state, never on the matching valid.
  always_comb begin
    state_nx    = state;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    w_en        = 1'b0;
    r_en        = 1'b0;
    err_timeout = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nx = op_is_write(op) ? ST_LOAD : ST_READ;
      end
      ST_LOAD: begin
        wr_ready = 1'b1;
        if (wr_valid) state_nx = ST_SHIFT;
      end
      ST_SHIFT: if (ser_done) state_nx = ST_GAP;
      ST_GAP:   state_nx = ST_WRITE;
      ST_WRITE: begin
        w_en     = 1'b1;
        state_nx = last_row ? ST_IDLE : ST_LOAD;
      end
      ST_READ: begin
        r_en     = 1'b1;
        state_nx = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (sram_data_valid) begin
          state_nx = last_row ? ST_IDLE : ST_READ;
        end else if (to_expire) begin
          err_timeout = 1'b1;
          state_nx    = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      addr_q   <= '0;
      rem_q    <= '0;
      to_cnt   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_addr  <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (state == ST_IDLE && cmd_valid) begin
        addr_q <= cmd_addr;
        rem_q  <= cmd_rows;
      end
      // Address advances only between rows, so it holds through each row's strobe.
      if (row_done && !last_row) begin
        addr_q <= addr_q + 1'b1;
        rem_q  <= rem_q - 1'b1;
      end
      if (state == ST_READ)         to_cnt <= '0;
      else if (state == ST_WAIT_RD) to_cnt <= to_cnt + 1'b1;
      if (state == ST_WAIT_RD && sram_data_valid) begin
        rd_valid <= 1'b1;
        rd_data  <= sram_data_out;
        rd_addr  <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl: a per-cycle expected trace built from transaction rules, replayed and compared.
module tb_sram_burst_ctrl;

  localparam int MAXC = 40000;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT (LANES=1) ----------------
  logic       arst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [3:0] cmd_addr = '0, cmd_len = '0;
  logic       wr_valid = 1'b0, wr_ready;
  logic [7:0] wr_data = '0;
  logic [0:0] serial_in;
  logic       shift, w_en, r_en;
  logic [3:0] addr;
  logic       sram_data_valid = 1'b0;
  logic [7:0] sram_data_out = '0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [3:0] rd_addr;
  logic       busy, err_timeout;
  logic [2:0] dbg_state;

  sram_burst_ctrl #(.ROWS(16), .COLS(8), .LANES(1), .SHIFT_DIV(2), .RD_TIMEOUT(8)) dut (
    .clk(clk), .arst_n(arst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .serial_in(serial_in), .shift(shift), .w_en(w_en), .r_en(r_en), .addr(addr),
    .sram_data_valid(sram_data_valid), .sram_data_out(sram_data_out),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_addr(rd_addr),
    .busy(busy), .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  // ---------------- second DUT (LANES=2) ----------------
  logic       arst2_n = 1'b0, c2_cmd_valid = 1'b0, c2_cmd_ready;
  logic [1:0] c2_cmd_op = '0;
  logic [3:0] c2_cmd_addr = '0, c2_cmd_len = '0;
  logic       c2_wr_valid = 1'b0, c2_wr_ready;
  logic [7:0] c2_wr_data = '0;
  logic [1:0] c2_serial;
  logic       c2_shift, c2_w_en, c2_r_en;
  logic [3:0] c2_addr;
  logic       c2_rd_valid;
  logic [7:0] c2_rd_data;
  logic [3:0] c2_rd_addr;
  logic       c2_busy, c2_err;
  logic [2:0] c2_dbg;

  sram_burst_ctrl #(.ROWS(16), .COLS(8), .LANES(2), .SHIFT_DIV(2), .RD_TIMEOUT(8)) dut2 (
    .clk(clk), .arst_n(arst2_n), .cmd_valid(c2_cmd_valid), .cmd_ready(c2_cmd_ready),
    .cmd_op(c2_cmd_op), .cmd_addr(c2_cmd_addr), .cmd_len(c2_cmd_len),
    .wr_valid(c2_wr_valid), .wr_ready(c2_wr_ready), .wr_data(c2_wr_data),
    .serial_in(c2_serial), .shift(c2_shift), .w_en(c2_w_en), .r_en(c2_r_en), .addr(c2_addr),
    .sram_data_valid(1'b0), .sram_data_out(8'h00),
    .rd_valid(c2_rd_valid), .rd_data(c2_rd_data), .rd_addr(c2_rd_addr),
    .busy(c2_busy), .err_timeout(c2_err), .dbg_state(c2_dbg)
  );

  // ---------------- expected trace ----------------
  typedef struct {
    logic       arst_n, cmd_valid;
    logic [1:0] cmd_op;
    logic [3:0] cmd_addr, cmd_len;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       sram_dv;
    logic [7:0] sram_do;
    logic       e_cmd_ready, e_wr_ready, e_shift, e_serial, e_w_en, e_r_en, e_busy, e_err;
    logic [3:0] e_addr;
    logic       e_rd_valid;
    logic [7:0] e_rd_data;
    logic [3:0] e_rd_addr;
  } cyc_t;

  cyc_t       tr[MAXC];
  int         n_tr = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [3:0] m_addr = '0;
  logic [7:0] mem[16];

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int rows_of(logic [1:0] op, logic [3:0] len);
    if (!op[1]) return 1;
    return (len == 4'd0) ? 16 : int'(len);
  endfunction

  // One cycle: random don't-care inputs, expected outputs for an idle or busy controller.
  function automatic int add_cyc(bit busy_cyc);
    int i = n_tr;
    n_tr++;
    tr[i].arst_n      = 1'b1;
    tr[i].cmd_valid   = busy_cyc ? 1'($urandom_range(0, 1)) : 1'b0;
    tr[i].cmd_op      = 2'($urandom);
    tr[i].cmd_addr    = 4'($urandom);
    tr[i].cmd_len     = 4'($urandom);
    tr[i].wr_valid    = 1'($urandom_range(0, 1));
    tr[i].wr_data     = 8'($urandom);
    tr[i].sram_dv     = 1'($urandom_range(0, 1));
    tr[i].sram_do     = 8'($urandom);
    tr[i].e_cmd_ready = !busy_cyc;
    tr[i].e_busy      = busy_cyc;
    tr[i].e_wr_ready  = 1'b0;
    tr[i].e_shift     = 1'b0;
    tr[i].e_serial    = 1'b0;
    tr[i].e_w_en      = 1'b0;
    tr[i].e_r_en      = 1'b0;
    tr[i].e_err       = 1'b0;
    tr[i].e_addr      = m_addr;
    return i;
  endfunction

  task automatic do_idle(input int n);
    repeat (n) void'(add_cyc(1'b0));
  endtask

  task automatic do_reset(input int n);
    int i;
    m_addr = '0;
    repeat (n) begin
      i = add_cyc(1'b0);
      tr[i].arst_n = 1'b0;
    end
  endtask

  function automatic int accept(logic [1:0] op, logic [3:0] a, logic [3:0] len);
    int i = add_cyc(1'b0);
    tr[i].cmd_valid = 1'b1;
    tr[i].cmd_op    = op;
    tr[i].cmd_addr  = a;
    tr[i].cmd_len   = len;
    m_addr = a;
    return i;
  endfunction

  // Write: per row, LOAD (gap then handshake), 16 shift cycles, GAP, WRITE.
  // abort_after >= 0 asserts reset after that many shift cycles of the first row.
  task automatic do_write(input logic [1:0] op, input logic [3:0] a, input logic [3:0] len,
                          input logic [7:0] d0, input int gapmax, input int abort_after,
                          output int hs0, output int wen0);
    int i, rows;
    logic [7:0] d;
    rows = rows_of(op, len);
    void'(accept(op, a, len));
    hs0 = -1; wen0 = -1;
    for (int r = 0; r < rows; r++) begin
      d = (r == 0) ? d0 : 8'($urandom);
      repeat ($urandom_range(0, gapmax)) begin
        i = add_cyc(1'b1);
        tr[i].wr_valid   = 1'b0;
        tr[i].e_wr_ready = 1'b1;
      end
      i = add_cyc(1'b1);
      tr[i].wr_valid   = 1'b1;
      tr[i].wr_data    = d;
      tr[i].e_wr_ready = 1'b1;
      if (r == 0) hs0 = i;
      for (int j = 0; j < 16; j++) begin
        if (j == abort_after) begin
          do_reset(2);
          return;
        end
        i = add_cyc(1'b1);
        tr[i].e_shift  = 1'b1;
        tr[i].e_serial = d[7 - j/2];
      end
      void'(add_cyc(1'b1));
      i = add_cyc(1'b1);
      tr[i].e_w_en = 1'b1;
      mem[m_addr] = d;
      if (r == 0) wen0 = i;
      if (r < rows - 1) m_addr = m_addr + 4'd1;
    end
  endtask

  // Read: per row, READ then up to 8 wait cycles; response on wait cycle k (k=9 means none).
  task automatic do_read(input logic [1:0] op, input logic [3:0] a, input logic [3:0] len,
                         input int fixed_k);
    int i, rows, k;
    bit timed_out;
    rows = rows_of(op, len);
    void'(accept(op, a, len));
    for (int r = 0; r < rows; r++) begin
      i = add_cyc(1'b1);
      tr[i].e_r_en = 1'b1;
      k = (fixed_k > 0) ? fixed_k : $urandom_range(1, 9);
      timed_out = 1'b0;
      for (int w = 1; w <= 8; w++) begin
        i = add_cyc(1'b1);
        tr[i].sram_dv = (w == k);
        if (w == k) begin
          tr[i].sram_do        = mem[m_addr];
          tr[i+1].e_rd_valid   = 1'b1;
          tr[i+1].e_rd_data    = mem[m_addr];
          tr[i+1].e_rd_addr    = m_addr;
          break;
        end else if (w == 8) begin
          tr[i].e_err = 1'b1;
          timed_out   = 1'b1;
        end
      end
      if (timed_out) break;
      if (r < rows - 1) m_addr = m_addr + 4'd1;
    end
  endtask

  // ---------------- stimulus build + run ----------------
  initial begin
    int hs, wen, dummy_hs, dummy_wen;
    int rb_s, rb_e, bw_s, bw_e, to_s, to_e;
    int cnt, first_a, last_a, last_i, i_ren, i_err, n_ren, n_err, n_rdv;
    logic [31:0] acc32;
    logic [15:0] acc16;
    logic [7:0]  acc8;
    logic [1:0]  op;

    for (int i = 0; i < MAXC; i++) begin
      tr[i].e_rd_valid = 1'b0;
      tr[i].e_rd_data  = '0;
      tr[i].e_rd_addr  = '0;
    end
    for (int r = 0; r < 16; r++) mem[r] = 8'(r * 3);

    do_reset(3);
    do_idle(2);
    do_write(2'b00, 4'd5, 4'd0, 8'hA5, 0, -1, hs, wen);
    do_idle(2);
    rb_s = n_tr;
    do_read(2'b11, 4'd14, 4'd4, 2);
    rb_e = n_tr;
    do_idle(1);
    bw_s = n_tr;
    do_write(2'b10, 4'd0, 4'd0, 8'($urandom), 2, -1, dummy_hs, dummy_wen);
    bw_e = n_tr;
    do_idle(1);
    to_s = n_tr;
    do_read(2'b11, 4'd7, 4'd3, 9);
    to_e = n_tr;
    do_idle(2);
    do_write(2'b00, 4'd9, 4'd0, 8'hFF, 0, 5, dummy_hs, dummy_wen);
    do_idle(1);
    do_write(2'b00, 4'd2, 4'd0, 8'h5A, 1, -1, dummy_hs, dummy_wen);
    do_idle(1);
    for (int t = 0; t < 40 && n_tr < MAXC - 1000; t++) begin
      op = 2'($urandom);
      if (op[0]) do_read(op, 4'($urandom), 4'($urandom_range(0, 5)), 0);
      else       do_write(op, 4'($urandom), 4'($urandom_range(0, 5)), 8'($urandom), 3, -1,
                          dummy_hs, dummy_wen);
      do_idle($urandom_range(0, 2));
    end
    do_idle(3);

    // Literal pins on the model itself.
    chk("model_wen_latency", hs, wen - hs, 18);
    cnt = 0; acc8 = '0;
    for (int i = hs + 1; i < wen; i++) if (tr[i].e_shift) cnt++;
    for (int j = 0; j < 8; j++) acc8 = {acc8[6:0], tr[hs + 1 + 2*j].e_serial};
    chk("model_shift_cycles", hs, cnt, 16);
    chk("model_serial_word", hs, 32'(acc8), 32'h0000_00A5);
    chk("model_wen_addr", wen, 32'(tr[wen].e_addr), 32'd5);

    cnt = 0; acc32 = '0; acc16 = '0;
    for (int i = rb_s; i <= rb_e; i++) if (tr[i].e_rd_valid) begin
      cnt++;
      acc32 = {acc32[23:0], tr[i].e_rd_data};
      acc16 = {acc16[11:0], tr[i].e_rd_addr};
    end
    chk("model_brd_count", rb_s, cnt, 4);
    chk("model_brd_data", rb_s, acc32, {8'd42, 8'd45, 8'd0, 8'd3});
    chk("model_brd_addr", rb_s, 32'(acc16), 32'h0000_EF01);

    cnt = 0; first_a = -1; last_a = -1; last_i = bw_s;
    for (int i = bw_s; i < bw_e; i++) if (tr[i].e_w_en) begin
      if (first_a < 0) first_a = int'(tr[i].e_addr);
      last_a = int'(tr[i].e_addr);
      last_i = i;
      cnt++;
    end
    chk("model_bwr_count", bw_s, cnt, 16);
    chk("model_bwr_first", bw_s, first_a, 0);
    chk("model_bwr_last", bw_s, last_a, 15);
    chk("model_bwr_busy_fall", last_i, 32'(tr[last_i + 1].e_busy), 32'd0);

    n_ren = 0; n_err = 0; n_rdv = 0; i_ren = 0; i_err = 0;
    for (int i = to_s; i <= to_e; i++) begin
      if (tr[i].e_r_en)     begin n_ren++; i_ren = i; end
      if (tr[i].e_err)      begin n_err++; i_err = i; end
      if (tr[i].e_rd_valid) n_rdv++;
    end
    chk("model_to_delay", to_s, i_err - i_ren, 8);
    chk("model_to_reads", to_s, n_ren, 1);
    chk("model_to_errs", to_s, n_err, 1);
    chk("model_to_rdvalid", to_s, n_rdv, 0);
    chk("model_to_idle", to_e, 32'(tr[to_e].e_cmd_ready), 32'd1);

    fork
      begin : driver
        for (int i = 0; i < n_tr; i++) begin
          arst_n          = tr[i].arst_n;
          cmd_valid       = tr[i].cmd_valid;
          cmd_op          = tr[i].cmd_op;
          cmd_addr        = tr[i].cmd_addr;
          cmd_len         = tr[i].cmd_len;
          wr_valid        = tr[i].wr_valid;
          wr_data         = tr[i].wr_data;
          sram_data_valid = tr[i].sram_dv;
          sram_data_out   = tr[i].sram_do;
          @(posedge clk);
          #1;
        end
      end
      begin : compare
        for (int i = 0; i < n_tr; i++) begin
          @(negedge clk);
          chk("cmd_ready", i, 32'(cmd_ready), 32'(tr[i].e_cmd_ready));
          chk("wr_ready", i, 32'(wr_ready), 32'(tr[i].e_wr_ready));
          chk("shift", i, 32'(shift), 32'(tr[i].e_shift));
          chk("serial_in", i, 32'(serial_in), 32'(tr[i].e_serial));
          chk("w_en", i, 32'(w_en), 32'(tr[i].e_w_en));
          chk("r_en", i, 32'(r_en), 32'(tr[i].e_r_en));
          chk("addr", i, 32'(addr), 32'(tr[i].e_addr));
          chk("busy", i, 32'(busy), 32'(tr[i].e_busy));
          chk("err_timeout", i, 32'(err_timeout), 32'(tr[i].e_err));
          chk("rd_valid", i, 32'(rd_valid), 32'(tr[i].e_rd_valid));
          if (tr[i].e_rd_valid) begin
            chk("rd_data", i, 32'(rd_data), 32'(tr[i].e_rd_data));
            chk("rd_addr", i, 32'(rd_addr), 32'(tr[i].e_rd_addr));
          end
        end
      end
      begin : lanes2
        logic [7:0] d2;
        logic [1:0] e2;
        logic [3:0] l1, l0;
        d2 = 8'h3C; l1 = '0; l0 = '0;
        @(negedge clk);
        chk("l2_reset_ready", 0, 32'(c2_cmd_ready), 32'd1);
        chk("l2_reset_shift", 0, 32'(c2_shift), 32'd0);
        @(posedge clk); #1;
        arst2_n = 1'b1; c2_cmd_valid = 1'b1; c2_cmd_op = 2'b00; c2_cmd_addr = 4'd3;
        @(posedge clk); #1;
        c2_cmd_valid = 1'b0; c2_wr_valid = 1'b1; c2_wr_data = d2;
        @(posedge clk); #1;
        c2_wr_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
          @(negedge clk);
          for (int l = 0; l < 2; l++) e2[l] = (c <= 8) ? d2[l*4 + 3 - (c-1)/2] : 1'b0;
          chk("l2_shift", c, 32'(c2_shift), 32'(c <= 8));
          chk("l2_serial", c, 32'(c2_serial), 32'(e2));
          chk("l2_w_en", c, 32'(c2_w_en), 32'(c == 10));
          if (c == 10) chk("l2_addr", c, 32'(c2_addr), 32'd3);
          if (c <= 8 && (c % 2) == 1) begin
            l1 = {l1[2:0], c2_serial[1]};
            l0 = {l0[2:0], c2_serial[0]};
          end
        end
        chk("l2_lane1_seq", 0, 32'(l1), 32'b0011);
        chk("l2_lane0_seq", 0, 32'(l0), 32'b1100);
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_burst_ctrl.md
Name: sram_burst_ctrl

Overview:
- Synthesizable RTL master for the serial-load SRAM top (serial_in/shift/w_en/r_en/addr/data_valid/data_out).
- Accepts single or burst read/write commands on a valid/ready port, serializes write words over 1..N lanes with a programmable bit period, and issues w_en/r_en pulses.
- Captures read data into a tagged response stream.
- Replaces the bench-only write/read sequencing with a reusable block placed between the system command fabric and sram_top.

Parameters:
- ROWS, 16, SRAM word count (power of two, >=2)
- COLS, 8, SRAM word width
- LANES, 1, serial lanes driven in parallel; COLS % LANES == 0
- SHIFT_DIV, 2, clocks each serial bit is held with shift=1 (>=1)
- RD_TIMEOUT, 8, max clocks to wait for sram_data_valid after r_en (>=1)

Ports:
- clk  in  1  system clock
- arst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00 write, 01 read, 10 burst write, 11 burst read
- cmd_addr  in  $clog2(ROWS)  start row
- cmd_len  in  $clog2(ROWS)  burst row count; 0 means ROWS; ignored for single ops
- wr_valid  in  1  write word valid
- wr_ready  out  1  high only in LOAD
- wr_data  in  COLS  write word
- serial_in  out  LANES  serial data to SRAM shift register
- shift  out  1  shift strobe
- w_en  out  1  write pulse
- r_en  out  1  read pulse
- addr  out  $clog2(ROWS)  SRAM row address
- sram_data_valid  in  1  SRAM read data valid
- sram_data_out  in  COLS  SRAM read data
- rd_valid  out  1  one-cycle read response strobe, no backpressure
- rd_data  out  COLS  captured read word
- rd_addr  out  $clog2(ROWS)  row of rd_data
- busy  out  1  state != IDLE
- err_timeout  out  1  one-cycle pulse on read timeout

Behaviour:
- Single clock clk; reset arst_n is asynchronous, active-low.
- Reset, including mid-operation: state IDLE, all outputs 0 except cmd_ready=1. Latched word, counters and address are cleared. No pending w_en or r_en survives reset.
- States: IDLE, LOAD, SHIFT, GAP, WRITE, READ, WAIT_RD.
- IDLE: on cmd_valid&cmd_ready, latch op, addr=cmd_addr and remaining = (single ? 1 : (cmd_len==0 ? ROWS : cmd_len)). Writes go to LOAD, reads go to READ.
- LOAD: wr_ready=1; on wr_valid, latch wr_data and go to SHIFT.
- SHIFT: lasts (COLS/LANES)*SHIFT_DIV cycles with shift=1.
  - Lane l carries slice wr_data[(l+1)*W-1 : l*W], W=COLS/LANES, MSB first.
  - Each bit is stable for SHIFT_DIV cycles.
- GAP: one cycle, shift=0, serial_in=0.
- WRITE: one cycle, w_en=1.
- READ: one cycle, r_en=1. Then WAIT_RD; its timeout counter starts the next cycle.
- WAIT_RD:
  - On sram_data_valid: rd_valid=1 next cycle, with rd_data=sram_data_out and rd_addr=addr.
  - If RD_TIMEOUT cycles elapse without valid: err_timeout pulse, abort the remaining burst, go to IDLE.
  - Valid arriving on the expiry cycle counts as data; no error.
- After WRITE or a completed read: decrement remaining. If nonzero, addr = addr+1 mod ROWS (ROWS-1 wraps to 0), then LOAD or READ. Otherwise IDLE.
- addr is stable from command accept through the final WRITE/READ of each row.
- Write latency, single write: wr handshake at edge 0 gives shift high for cycles 1..(COLS/LANES)*SHIFT_DIV, then GAP, then w_en the following cycle.
- sram_data_valid outside WAIT_RD is ignored.
- cmd_valid while busy is not accepted and does not disturb the operation in flight.

Decomposition:
- Package sram_pkg:
  - ROWS/COLS defaults
  - sram_op_e enum (OP_WR, OP_RD, OP_BWR, OP_BRD)
  - ctrl_state_e enum
  - ADDR_W = $clog2(ROWS)
- Sub-module sram_serializer: PISO with LANES slices and SHIFT_DIV bit-period counter.
  - Inputs: load, word.
  - Outputs: serial_in, shift, done.
  - Instantiated once.

Test Plan:
- Single write, COLS=8, LANES=1, SHIFT_DIV=2, addr=5, data=8'hA5 -> shift high 16 cycles, serial_in sequence 1,0,1,0,0,1,0,1 each held 2 cycles, addr=5, GAP, then w_en one cycle at cycle 18.
- LANES=2, data=8'h3C -> lane1 carries 0,0,1,1 and lane0 carries 1,1,0,0; shift high 8 cycles.
- Burst read addr=14, len=4, ROWS=16, SRAM model returns data=row*3 after 2 cycles -> rd_valid four times with rd_addr 14,15,0,1 and rd_data 42,45,0,3.
- Burst write len=0 on ROWS=16 -> 16 w_en pulses covering addr 0..15 in order; busy falls after the last.
- Read with sram_data_valid never asserted, RD_TIMEOUT=8, burst len=3 -> err_timeout pulse 8 cycles after r_en, no rd_valid, controller returns to IDLE.
- arst_n low during SHIFT -> shift, serial_in and w_en go to 0 immediately, cmd_ready=1. A new write after reset shifts the new word with no residue.
